// File: rtl/axis_i2c_arbiter.sv
// ----------------------------------------------------------------------------
// axis_i2c_arbiter
//
// Shares one AXI-Stream I2C engine between two requesters. A request is taken
// from one of two AXIS slaves, handed to the engine on the AXIS master and the
// owner is held until the engine reports done (STOP complete) or a completion
// timeout expires. Contention is resolved round-robin: when both requesters
// are valid, the port not served last wins.
//
// Parameters
//   DATA_W   width of every tdata bus (matches the engine's AXIS data width)
//   TIMEOUT  cycles to wait for done after the engine accepted the word
//            (2..65535)
//
// Ports
//   clk, arst_n                   clock, asynchronous active-low reset
//   s0_tvalid/s0_tready/s0_tdata  requester 0 AXIS slave
//   s1_tvalid/s1_tready/s1_tdata  requester 1 AXIS slave
//   m_tvalid/m_tready/m_tdata     AXIS master towards the I2C engine
//   done                          engine completion pulse
//   grant                         one-hot owner, 2'b00 when nothing in flight
//   busy                          high whenever not idle
//   timeout_err                   one-cycle pulse on a completion timeout
// ----------------------------------------------------------------------------
module axis_i2c_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              arst_n,

  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s0_tdata,

  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic [DATA_W-1:0] s1_tdata,

  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,

  input  logic              done,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;
  logic              terr_q, terr_d;

  logic any_valid;
  logic sel;
  logic accept;

  // Round-robin pick; only meaningful while any_valid is high.
  always_comb begin
    any_valid = s0_tvalid | s1_tvalid;
    if (s0_tvalid && s1_tvalid) begin
      sel = ~last_q;
    end else begin
      sel = s1_tvalid;
    end
  end

  // tready is gated by arst_n so both slaves read as not-ready during reset
  // even though the idle offer is combinational from tvalid.
  always_comb begin
    s0_tready = arst_n & (state_q == StIdle) & any_valid & ~sel;
    s1_tready = arst_n & (state_q == StIdle) & any_valid & sel;
    accept    = (s0_tvalid & s0_tready) | (s1_tvalid & s1_tready);
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    terr_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          hold_d  = sel ? s1_tdata : s0_tdata;
          grant_d = sel ? 2'b10 : 2'b01;
          last_d  = sel;
          cnt_d   = '0;
          state_d = StSend;
        end
      end

      // done is deliberately ignored until the engine has taken the word.
      StSend: begin
        if (m_tready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end

      // done takes priority over a timeout landing on the same cycle.
      StWait: begin
        if (done) begin
          grant_d = 2'b00;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          grant_d = 2'b00;
          terr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      last_q  <= 1'b1;  // port 0 wins the first contention
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    m_tvalid    = (state_q == StSend);
    m_tdata     = m_tvalid ? hold_q : '0;
    busy        = (state_q != StIdle);
    grant       = grant_q;
    timeout_err = terr_q;
  end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axis_i2c_arbiter
//
// Transaction-level bench: each transfer is described by who requests, the
// data words, how long the engine back-pressures and when (if ever) done
// arrives. The expected waveform is derived from those numbers and a
// round-robin "last served" record; a randomized phase follows directed cases.
// ----------------------------------------------------------------------------
module tb_axis_i2c_arbiter;

  localparam int unsigned DataW   = 8;
  localparam int unsigned Timeout = 8;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             s0_tvalid, s0_tready;
  logic [DataW-1:0] s0_tdata;
  logic             s1_tvalid, s1_tready;
  logic [DataW-1:0] s1_tdata;
  logic             m_tvalid, m_tready;
  logic [DataW-1:0] m_tdata;
  logic             done;
  logic [1:0]       grant;
  logic             busy;
  logic             timeout_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  int   model_last;  // port served most recently
  logic exp_terr;    // timeout pulse expected in the coming idle cycle

  axis_i2c_arbiter #(
    .DATA_W  (DataW),
    .TIMEOUT (Timeout)
  ) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .s0_tvalid   (s0_tvalid),
    .s0_tready   (s0_tready),
    .s0_tdata    (s0_tdata),
    .s1_tvalid   (s1_tvalid),
    .s1_tready   (s1_tready),
    .s1_tdata    (s1_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .done        (done),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_requesters();
    s0_tvalid = 1'($urandom_range(0, 1));
    s1_tvalid = 1'($urandom_range(0, 1));
    s0_tdata  = 8'($urandom);
    s1_tdata  = 8'($urandom);
  endtask

  task automatic check_all_zero(input string ph);
    check_eq({ph, "_busy"}, 32'(busy), 0);
    check_eq({ph, "_grant"}, 32'(grant), 0);
    check_eq({ph, "_mvalid"}, 32'(m_tvalid), 0);
    check_eq({ph, "_mdata"}, 32'(m_tdata), 0);
    check_eq({ph, "_terr"}, 32'(timeout_err), 0);
    check_eq({ph, "_s0rdy"}, 32'(s0_tready), 0);
    check_eq({ph, "_s1rdy"}, 32'(s1_tready), 0);
  endtask

  // Asserts reset mid-cycle (no clock edge) so the outputs must clear
  // asynchronously, holds it across one edge, then releases.
  task automatic do_reset(input string ph);
    arst_n    = 1'b0;
    done      = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    #1;
    check_all_zero({ph, "_rst_async"});
    next_cycle();
    check_all_zero({ph, "_rst_held"});
    arst_n     = 1'b1;
    model_last = 1;
    exp_terr   = 1'b0;
  endtask

  task automatic idle_cycle();
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    done      = 1'b0;
    #1;
    check_eq("none_s0rdy", 32'(s0_tready), 0);
    check_eq("none_s1rdy", 32'(s1_tready), 0);
    check_eq("none_busy", 32'(busy), 0);
    check_eq("none_terr", 32'(timeout_err), 32'(exp_terr));
    exp_terr = 1'b0;
    next_cycle();
  endtask

  // pat: 1 = s0 only, 2 = s1 only, 3 = both.  bp: cycles of m_tready=0 in SEND.
  // k: WAIT cycle index carrying done (>= Timeout means never).
  // rst_send / rst_wait: cycle index at which reset hits (-1 = none).
  task automatic run_txn(input int pat, input logic [7:0] d0, input logic [7:0] d1,
                         input int bp, input int k, input int rst_send, input int rst_wait);
    int         sel;
    logic [7:0] exp_data;
    logic [1:0] exp_grant;

    s0_tvalid = (pat != 2);
    s1_tvalid = (pat != 1);
    s0_tdata  = d0;
    s1_tdata  = d1;
    done      = 1'b0;
    m_tready  = 1'($urandom_range(0, 1));
    if (pat == 3) sel = 1 - model_last;
    else          sel = (pat == 2) ? 1 : 0;
    #1;
    check_eq("idle_busy", 32'(busy), 0);
    check_eq("idle_grant", 32'(grant), 0);
    check_eq("idle_mvalid", 32'(m_tvalid), 0);
    check_eq("idle_mdata", 32'(m_tdata), 0);
    check_eq("idle_terr", 32'(timeout_err), 32'(exp_terr));
    check_eq("idle_s0rdy", 32'(s0_tready), 32'(sel == 0));
    check_eq("idle_s1rdy", 32'(s1_tready), 32'(sel == 1));
    next_cycle();

    model_last = sel;
    exp_data   = (sel == 1) ? d1 : d0;
    exp_grant  = (sel == 1) ? 2'b10 : 2'b01;
    exp_terr   = 1'b0;

    for (int i = 0; i <= bp; i++) begin
      randomize_requesters();
      m_tready = (i == bp);
      done     = 1'($urandom_range(0, 1));
      if (i == rst_send) begin
        do_reset("send");
        return;
      end
      #1;
      check_eq("send_mvalid", 32'(m_tvalid), 1);
      check_eq("send_mdata", 32'(m_tdata), 32'(exp_data));
      check_eq("send_grant", 32'(grant), 32'(exp_grant));
      check_eq("send_busy", 32'(busy), 1);
      check_eq("send_s0rdy", 32'(s0_tready), 0);
      check_eq("send_s1rdy", 32'(s1_tready), 0);
      check_eq("send_terr", 32'(timeout_err), 0);
      next_cycle();
    end

    for (int j = 0; j < int'(Timeout); j++) begin
      randomize_requesters();
      m_tready = 1'($urandom_range(0, 1));
      done     = (j == k);
      if (j == rst_wait) begin
        do_reset("wait");
        return;
      end
      #1;
      check_eq("wait_mvalid", 32'(m_tvalid), 0);
      check_eq("wait_mdata", 32'(m_tdata), 0);
      check_eq("wait_grant", 32'(grant), 32'(exp_grant));
      check_eq("wait_busy", 32'(busy), 1);
      check_eq("wait_s0rdy", 32'(s0_tready), 0);
      check_eq("wait_s1rdy", 32'(s1_tready), 0);
      check_eq("wait_terr", 32'(timeout_err), 0);
      next_cycle();
      if (j == k) break;
    end
    done     = 1'b0;
    exp_terr = (k >= int'(Timeout));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat, bp, k, rs, rw;

    arst_n     = 1'b1;
    s0_tvalid  = 1'b0;
    s1_tvalid  = 1'b0;
    s0_tdata   = '0;
    s1_tdata   = '0;
    m_tready   = 1'b0;
    done       = 1'b0;
    model_last = 1;
    exp_terr   = 1'b0;

    #2;
    arst_n    = 1'b0;
    s0_tvalid = 1'b1;
    s1_tvalid = 1'b1;
    #2;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Contention straight after reset: 0, 1, 0 ...
    run_txn(3, 8'h11, 8'h22, 0, 2, -1, -1);
    run_txn(3, 8'h11, 8'h22, 0, 0, -1, -1);
    run_txn(3, 8'h11, 8'h22, 0, 3, -1, -1);
    run_txn(3, 8'h11, 8'h22, 1, 1, -1, -1);
    // Single request
    run_txn(1, 8'hA5, 8'h00, 0, 5, -1, -1);
    idle_cycle();
    // Backpressure for five cycles
    run_txn(2, 8'h3C, 8'hC3, 5, 4, -1, -1);
    // Completion timeout, then done landing on the last count
    run_txn(1, 8'h5A, 8'h00, 0, Timeout, -1, -1);
    idle_cycle();
    run_txn(2, 8'h00, 8'h77, 2, Timeout - 1, -1, -1);
    run_txn(1, 8'h42, 8'h00, 0, Timeout, -1, -1);
    // Reset in WAIT, then port 0 must win
    run_txn(2, 8'h00, 8'h99, 0, Timeout, -1, 3);
    run_txn(3, 8'hE1, 8'hE2, 0, 1, -1, -1);
    run_txn(3, 8'hE1, 8'hE2, 0, 1, -1, -1);
    // Reset in SEND
    run_txn(3, 8'h10, 8'h20, 3, 1, 1, -1);
    run_txn(3, 8'h30, 8'h40, 0, 0, -1, -1);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      pat = int'($urandom_range(1, 3));
      bp  = int'($urandom_range(0, 4));
      case ($urandom_range(0, 3))
        0:       k = int'(Timeout);
        1:       k = int'(Timeout) - 1;
        default: k = int'($urandom_range(0, Timeout - 1));
      endcase
      rs = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
      rw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, Timeout - 1)) : -1;
      run_txn(pat, 8'($urandom), 8'($urandom), bp, k, rs, rw);
    end
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_i2c_arbiter.md
AXIS_I2C_ARBITER -- requirements
Module: axis_i2c_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, width of every tdata bus; equals AXIS_DATA_WIDTH of the I2C engine.
REQ-002 Parameter TIMEOUT, default 64, the maximum number of cycles to wait for engine completion; legal range 2..65535.
REQ-003 Port clk, input, 1, the single clock; all logic SHALL be rising-edge only.
REQ-004 Port arst_n, input, 1, asynchronous active-low reset.
REQ-005 Ports s0_tvalid/s0_tready/s0_tdata, in/out/in, 1/1/DATA_W, requester 0 AXIS slave.
REQ-006 Ports s1_tvalid/s1_tready/s1_tdata, in/out/in, 1/1/DATA_W, requester 1 AXIS slave.
REQ-007 Ports m_tvalid/m_tready/m_tdata, out/in/out, 1/1/DATA_W, AXIS master to the shared I2C engine.
REQ-008 Port done, input, 1, single-cycle pulse from the engine when its STOP completes.
REQ-009 Port grant, output, 2, one-hot owner of the engine; 2'b00 when no transfer is in flight.
REQ-010 Port busy, output, 1, high in every state except IDLE.
REQ-011 Port timeout_err, output, 1, single-cycle pulse on a completion timeout.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SEND and WAIT.
REQ-013 In IDLE, sel is chosen combinationally:
- only one tvalid high: sel is that port;
- both high: sel is the port other than last;
- none high: no selection.
REQ-014 In IDLE, s<sel>_tready SHALL be 1 when any tvalid is high, and the other tready SHALL be 0; accept equals tvalid & tready.
REQ-015 On accept, the FSM SHALL:
- latch s<sel>_tdata into hold;
- set grant to the one-hot sel;
- set last to sel;
- clear cnt;
- move to SEND.
REQ-016 Outside IDLE, both s*_tready SHALL be 0.
REQ-017 In SEND:
- m_tvalid SHALL be 1 and m_tdata SHALL be hold, stable until the handshake;
- on m_tvalid & m_tready, move to WAIT and clear cnt;
- done is ignored in SEND.
REQ-018 In WAIT:
- m_tvalid SHALL be 0 and cnt increments each cycle;
- on done, clear grant and move to IDLE;
- else on cnt == TIMEOUT-1, clear grant, pulse timeout_err for 1 cycle and move to IDLE;
- done and the timeout in the same cycle SHALL count as done, with no error.
REQ-019 cnt SHALL be clog2(TIMEOUT) bits wide and SHALL NOT wrap inside WAIT.
REQ-020 Latency:
- tvalid in IDLE to m_tvalid is 1 cycle;
- done to IDLE is 1 cycle;
- the earliest next accept is the cycle after IDLE is entered.
REQ-021 m_tdata SHALL be 0 whenever m_tvalid is 0.
REQ-022 A requester dropping tvalid after acceptance SHALL NOT affect the transfer in flight.

Reset
REQ-023 While arst_n is 0, the block SHALL hold:
- state IDLE;
- hold, cnt and grant 0;
- last 1, so port 0 wins the first contention;
- m_tvalid, busy, timeout_err and both s*_tready 0.
REQ-024 Reset asserted mid-SEND or mid-WAIT SHALL abort the transfer immediately, with no timeout_err pulse; the next grant after reset follows REQ-013 using last = 1.

Verification
REQ-025 Single request: s0_tvalid=1, s0_tdata=8'hA5, m_tready held high -> s0_tready is 1 for 1 cycle, the next cycle shows m_tvalid=1 with m_tdata=8'hA5 and grant=01; done after 10 cycles -> busy=0 the cycle after done.
REQ-026 Contention after reset: s0 and s1 both valid with data 8'h11 and 8'h22 -> first grant=01 with data 8'h11, second grant=10 with data 8'h22, third grant=01; order strictly alternates.
REQ-027 Backpressure: m_tready=0 for 5 cycles in SEND -> m_tvalid and m_tdata=hold are stable all 5 cycles, both s*_tready are 0, and WAIT is entered on the first m_tready=1.
REQ-028 Timeout: TIMEOUT=8, done is never pulsed -> timeout_err pulses exactly 8 cycles after the WAIT entry cycle, grant=00, IDLE on the next cycle.
REQ-029 Simultaneous events: done on the cycle where cnt=TIMEOUT-1 -> no timeout_err and normal return to IDLE.
REQ-030 Reset mid-WAIT: arst_n pulled low for 1 cycle during WAIT -> all outputs 0 asynchronously; with both requesters valid afterwards, port 0 is granted first.
